seg_serial_driver: RTL and testbench

- Downstream stage of the hex-to-segment encoder: takes the 64-bit segment pattern (8 digits x 8 segments) and shifts it serially into the board's cascaded shift-register seven-segment chain.
- Produces the serial clock, data, clear and output-enable lines that drive the display.
- Handles one frame per start request, MSB first, with a programmable shift-clock rate and a busy/done handshake to the upstream stage.

---
 rtl/seg_serial_driver_if.sv | 53 +++++
 rtl/seg_serial_driver.sv | 169 ++++++++++++++++
 tb/tb_seg_serial_driver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_serial_driver_if.sv
// ---------------------------------------------------------------------------
// seg_serial_driver_if
//   Bundle between the segment encoder, the serial driver and the display
//   shift-register chain.
//
//   Signals
//     start    : frame request from upstream (sampled only while idle)
//     par_data : DATA_WIDTH-bit segment pattern, captured on accepted start
//     s_clk    : serial shift clock to the chain
//     s_dat    : serial data, MSB first
//     s_clr    : active-low chain clear
//     s_en     : display output enable (1 = show latched pattern)
//     busy     : frame in progress
//     done     : one-cycle end-of-frame pulse
//
//   Modports
//     master : upstream side, drives start/par_data, observes the rest
//     slave  : serial driver side
// ---------------------------------------------------------------------------
interface seg_serial_driver_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  start;
    logic [DATA_WIDTH-1:0] par_data;
    logic                  s_clk;
    logic                  s_dat;
    logic                  s_clr;
    logic                  s_en;
    logic                  busy;
    logic                  done;

    modport master (
        output start,
        output par_data,
        input  s_clk,
        input  s_dat,
        input  s_clr,
        input  s_en,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  par_data,
        output s_clk,
        output s_dat,
        output s_clr,
        output s_en,
        output busy,
        output done
    );
endinterface

// File: rtl/seg_serial_driver.sv
// ---------------------------------------------------------------------------
// seg_serial_driver
//   Shifts one DATA_WIDTH-bit segment pattern, MSB first, into a cascaded
//   shift-register seven-segment chain per accepted start request.
//   Each bit occupies one s_clk period: CLK_DIV clk cycles low followed by
//   CLK_DIV clk cycles high; the chain samples on the s_clk rising edge.
//
//   Ports
//     clk : system clock
//     rst : synchronous, active-high reset
//     bus : seg_serial_driver_if.slave (start, par_data in;
//           s_clk, s_dat, s_clr, s_en, busy, done out)
//
//   All outputs come straight from flops, so the chain sees no glitches.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; s_en holds last frame's enable
//   ST_LOW  | s_clk low, s_dat presenting the current bit
//   ST_HIGH | s_clk high, chain samples the current bit on entry
//   ST_DONE | one-cycle done pulse, start is ignored here
// ---------------------------------------------------------------------------
module seg_serial_driver #(
    parameter int DATA_WIDTH = 64,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_serial_driver_if.slave    bus
);

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam int PH_W  = $clog2(CLK_DIV) + 1;

    localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [PH_W-1:0]       r_phase;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_s_clk;
    logic                  r_s_clr;
    logic                  r_s_en;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [PH_W-1:0]       w_phase_nxt;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_s_clk_nxt;
    logic                  w_s_en_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // Phase timer is a down-counter: loaded with CLK_DIV-1 on entry to a
    // phase, the phase ends on the cycle it reads zero.
    logic w_phase_tc;
    logic w_last_bit;

    assign w_phase_tc = (r_phase == '0);
    assign w_last_bit = (r_bit == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_s_clk <= 1'b0;
            r_s_clr <= 1'b0;
            r_s_en  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_s_clk <= w_s_clk_nxt;
            r_s_clr <= 1'b1;
            r_s_en  <= w_s_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_s_clk_nxt = r_s_clk;
        w_s_en_nxt  = r_s_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_LOW;
                    w_phase_nxt = PH_LOAD;
                    w_bit_nxt   = '0;
                    w_shift_nxt = bus.par_data;
                    w_s_clk_nxt = 1'b0;
                    w_s_en_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            ST_LOW: begin
                if (w_phase_tc) begin
                    w_state_nxt = ST_HIGH;
                    w_phase_nxt = PH_LOAD;
                    w_s_clk_nxt = 1'b1;
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end

            ST_HIGH: begin
                if (w_phase_tc) begin
                    w_s_clk_nxt = 1'b0;
                    if (w_last_bit) begin
                        // Clearing the shifter also forces s_dat low.
                        w_state_nxt = ST_DONE;
                        w_shift_nxt = '0;
                        w_busy_nxt  = 1'b0;
                        w_s_en_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_phase_nxt = PH_LOAD;
                        w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
                        w_bit_nxt   = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // s_dat is the shifter MSB so data changes only together with the
    // falling s_clk edge and is stable across the whole LOW/HIGH pair.
    assign bus.s_clk = r_s_clk;
    assign bus.s_dat = r_shift[DATA_WIDTH-1];
    assign bus.s_clr = r_s_clr;
    assign bus.s_en  = r_s_en;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_seg_serial_driver.sv
module tb_seg_serial_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_serial_driver_if #(.DATA_WIDTH(64)) if_a ();
    seg_serial_driver_if #(.DATA_WIDTH(64)) if_b ();

    seg_serial_driver #(.DATA_WIDTH(64), .CLK_DIV(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    seg_serial_driver #(.DATA_WIDTH(64), .CLK_DIV(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observation model: reassemble the bits the chain would latch on each
    // s_clk rising edge and count busy cycles / done pulses.
    logic [63:0] bits_a = '0;
    int          rise_a = 0;
    int          busy_a = 0;
    int          done_a = 0;
    logic        prev_a = 1'b0;

    logic [63:0] bits_b = '0;
    int          rise_b = 0;
    int          busy_b = 0;
    int          done_b = 0;
    int          tog_err_b = 0;
    logic        prev_b = 1'b0;
    logic        prev_busy_b = 1'b0;

    always @(negedge clk) begin
        if (if_a.s_clk && !prev_a) begin
            bits_a = {bits_a[62:0], if_a.s_dat};
            rise_a++;
        end
        prev_a = if_a.s_clk;
        if (if_a.busy) busy_a++;
        if (if_a.done) done_a++;

        if (if_b.s_clk && !prev_b) begin
            bits_b = {bits_b[62:0], if_b.s_dat};
            rise_b++;
        end
        if (if_b.busy && prev_busy_b && (if_b.s_clk == prev_b)) tog_err_b++;
        prev_b      = if_b.s_clk;
        prev_busy_b = if_b.busy;
        if (if_b.busy) busy_b++;
        if (if_b.done) done_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        bits_a = '0; rise_a = 0; busy_a = 0; done_a = 0;
    endtask

    task automatic clear_b();
        bits_b = '0; rise_b = 0; busy_b = 0; done_b = 0; tog_err_b = 0;
    endtask

    // mode 0: plain, 1: par_data zeroed mid-frame, 2: stray starts while busy
    task automatic frame_a(input string tag, input logic [63:0] data, input int mode);
        int c;
        clear_a();
        if_a.par_data = data;
        if_a.start    = 1'b1;
        tick();
        chk({tag, "_busy0"}, {63'd0, if_a.busy}, 64'd1);
        chk({tag, "_msb0"}, {63'd0, if_a.s_dat}, {63'd0, data[63]});
        chk({tag, "_sen0"}, {63'd0, if_a.s_en}, 64'd0);
        if_a.start = 1'b0;
        c = 1;
        while (!if_a.done && c < 1000) begin
            if_a.start = (mode == 2) && (c == 10 || c == 100 || c == 255);
            if (mode == 1 && c == 70) if_a.par_data = '0;
            tick();
            c++;
        end
        if_a.start = 1'b0;
        chk({tag, "_done_seen"}, {63'd0, if_a.done}, 64'd1);
        chk({tag, "_done_busy"}, {63'd0, if_a.busy}, 64'd0);
        chk({tag, "_done_sen"}, {63'd0, if_a.s_en}, 64'd1);
        chk({tag, "_done_sclk_sdat"}, {62'd0, if_a.s_clk, if_a.s_dat}, 64'd0);
        tick();
        chk({tag, "_after_done"}, {62'd0, if_a.done, if_a.busy}, 64'd0);
        tick();
        tick();
        chk({tag, "_bits"}, bits_a, data);
        chk({tag, "_rises"}, 64'(rise_a), 64'd64);
        chk({tag, "_busy_len"}, 64'(busy_a), 64'd256);
        chk({tag, "_done_cnt"}, 64'(done_a), 64'd1);
        chk({tag, "_sen_hold"}, {63'd0, if_a.s_en}, 64'd1);
    endtask

    logic [63:0] rnd;
    logic [63:0] d1;
    logic [63:0] d2;
    int          c;

    initial begin
        if_a.start = 1'b0; if_a.par_data = '0;
        if_b.start = 1'b0; if_b.par_data = '0;

        // Reset
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_outputs", {58'd0, if_a.s_clk, if_a.s_dat, if_a.s_clr, if_a.s_en, if_a.busy, if_a.done}, 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_release_clr", {63'd0, if_a.s_clr}, 64'd1);
        chk("rst_release_rest", {59'd0, if_a.s_clk, if_a.s_dat, if_a.s_en, if_a.busy, if_a.done}, 64'd0);

        // Directed frames
        frame_a("single", 64'h8000_0000_0000_0001, 0);
        frame_a("pattern", 64'hC0F9_A4B0_9992_82F8, 1);

        // Random frames, including stray starts while busy
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom(), $urandom()};
            frame_a("random", rnd, (i == 2) ? 2 : 0);
        end
        rnd = {$urandom(), $urandom()};
        frame_a("ignore_start", rnd, 2);

        // Reset mid-frame
        clear_a();
        if_a.par_data = {$urandom(), $urandom()};
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
        for (c = 1; c < 70; c++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_outputs", {58'd0, if_a.s_clk, if_a.s_dat, if_a.s_clr, if_a.s_en, if_a.busy, if_a.done}, 64'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("midrst_no_done", 64'(done_a), 64'd0);
        chk("midrst_clr", {63'd0, if_a.s_clr}, 64'd1);
        rnd = {$urandom(), $urandom()};
        frame_a("post_rst", rnd, 0);

        // CLK_DIV=1 with start held high: back-to-back frames
        d1 = {$urandom(), $urandom()};
        d2 = {$urandom(), $urandom()};
        clear_b();
        if_b.par_data = d1;
        if_b.start = 1'b1;
        tick();
        c = 1;
        while (!if_b.done && c < 1000) begin
            tick();
            c++;
        end
        if_b.par_data = d2;
        chk("div1_done_seen", {63'd0, if_b.done}, 64'd1);
        chk("div1_busy_len", 64'(busy_b), 64'd128);
        chk("div1_bits", bits_b, d1);
        chk("div1_rises", 64'(rise_b), 64'd64);
        chk("div1_toggle", 64'(tog_err_b), 64'd0);
        tick();
        chk("div1_idle", {62'd0, if_b.busy, if_b.done}, 64'd0);
        tick();
        clear_b();
        chk("div1_restart", {63'd0, if_b.busy}, 64'd1);
        chk("div1_restart_msb", {63'd0, if_b.s_dat}, {63'd0, d2[63]});
        if_b.start = 1'b0;
        c = 1;
        while (!if_b.done && c < 1000) begin
            tick();
            c++;
        end
        chk("div1_f2_done_seen", {63'd0, if_b.done}, 64'd1);
        chk("div1_f2_busy_len", 64'(busy_b), 64'd128);
        chk("div1_f2_bits", bits_b, d2);
        tick(); tick();
        chk("div1_f2_idle", {62'd0, if_b.busy, if_b.done}, 64'd0);
        chk("div1_f2_done_cnt", 64'(done_b), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
